// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator car sequencers.
package elevator_pkg;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} car_state_t;
  typedef enum logic {UP, DOWN} dir_t;

  // Cycle counts at a 100 MHz system clock.
  localparam int MOVE_TICKS_2S = 200_000_000;
  localparam int DOOR_TICKS_3S = 300_000_000;

endpackage

// File: rtl/car_motion_controller_tick_timer.sv
// Restartable tick timer: expire is high on the cycle the count reaches term-1.
module tick_timer #(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expire = en && (count_reg == term - CNT_W'(1));

endmodule

// File: rtl/car_motion_controller.sv
// Per-car SCAN sequencer: pending-call bitmap, floor stepping and door dwell.
// Optional ESTOP_EN adds an estop input that freezes the FSM and timer.
module car_motion_controller
  import elevator_pkg::*;
#(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int CNT_W      = 30,
  parameter int MOVE_TICKS = MOVE_TICKS_2S,
  parameter int DOOR_TICKS = DOOR_TICKS_3S
) (
  input  logic               clk,
  input  logic               reset,
`ifdef ESTOP_EN
  input  logic               estop,
`endif
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_err,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               arrived
);

  localparam logic [FLOOR_W:0] FLOORS_LIM = (FLOOR_W + 1)'(FLOORS);

  car_state_t         state_reg, state_next;
  dir_t               dir_reg, dir_next;
  logic [FLOOR_W-1:0] floor_reg, floor_next;
  logic [FLOORS-1:0]  pending_reg, pending_next, set_mask, clr_mask;
  logic [FLOOR_W-1:0] up_floor, down_floor;
  logic               arrived_reg, req_err_reg;
  logic               req_ok, hold, freeze;
  logic               restart, timer_en, expire;
  logic [CNT_W-1:0]   term;

  function automatic logic bit_at(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (FLOOR_W'(i) == f) r = v[i];
    return r;
  endfunction

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (FLOOR_W'(i) == f);
    return m;
  endfunction

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (v[i] && (FLOOR_W'(i) > f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (v[i] && (FLOOR_W'(i) < f)) r = 1'b1;
    return r;
  endfunction

`ifdef ESTOP_EN
  assign freeze = estop;
`else
  assign freeze = 1'b0;
`endif

  assign req_ok   = req_valid && ({1'b0, req_floor} < FLOORS_LIM);
  // A call for the open floor is absorbed and only extends the dwell.
  assign hold     = req_ok && (state_reg == DOOR_OPEN) && (req_floor == floor_reg);
  assign set_mask = (req_ok && !hold) ? onehot(req_floor) : '0;

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    floor_next = floor_reg;
    clr_mask   = '0;
    restart    = 1'b0;
    up_floor   = floor_reg + FLOOR_W'(1);
    down_floor = floor_reg - FLOOR_W'(1);
    if (!freeze) begin
      case (state_reg)
        IDLE: begin
          if (bit_at(pending_reg, floor_reg)) begin
            state_next = DOOR_OPEN;
            clr_mask   = onehot(floor_reg);
          end else if (dir_reg == UP) begin
            if (any_above(pending_reg, floor_reg))      state_next = MOVE_UP;
            else if (any_below(pending_reg, floor_reg)) state_next = MOVE_DOWN;
          end else begin
            if (any_below(pending_reg, floor_reg))      state_next = MOVE_DOWN;
            else if (any_above(pending_reg, floor_reg)) state_next = MOVE_UP;
          end
        end
        MOVE_UP: begin
          if (expire) begin
            floor_next = up_floor;
            dir_next   = UP;
            if (bit_at(pending_reg, up_floor)) begin
              state_next = DOOR_OPEN;
              clr_mask   = onehot(up_floor);
            end else if (any_above(pending_reg, up_floor)) begin
              restart = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        MOVE_DOWN: begin
          if (expire) begin
            floor_next = down_floor;
            dir_next   = DOWN;
            if (bit_at(pending_reg, down_floor)) begin
              state_next = DOOR_OPEN;
              clr_mask   = onehot(down_floor);
            end else if (any_below(pending_reg, down_floor)) begin
              restart = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DOOR_OPEN: begin
          if (hold)        restart    = 1'b1;
          else if (expire) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
      if (state_next != state_reg) restart = 1'b1;
    end
  end

  assign pending_next = (pending_reg | set_mask) & ~clr_mask;
  assign timer_en     = !freeze && (state_reg != IDLE);
  assign term         = (state_reg == DOOR_OPEN) ? CNT_W'(DOOR_TICKS) : CNT_W'(MOVE_TICKS);

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .en     (timer_en),
    .term   (term),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      dir_reg     <= UP;
      floor_reg   <= '0;
      pending_reg <= '0;
      arrived_reg <= 1'b0;
      req_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      floor_reg   <= floor_next;
      pending_reg <= pending_next;
      arrived_reg <= (state_next == DOOR_OPEN) && (state_reg != DOOR_OPEN);
      req_err_reg <= req_valid && !req_ok;
    end
  end

  assign pending     = pending_reg;
  assign cur_floor   = floor_reg;
  assign moving_up   = (state_reg == MOVE_UP) && !freeze;
  assign moving_down = (state_reg == MOVE_DOWN) && !freeze;
  assign door_open   = (state_reg == DOOR_OPEN);
  assign arrived     = arrived_reg;
  assign req_err     = req_err_reg;

endmodule

// File: tb/tb_car_motion_controller.sv
// Scoreboard bench: stimulus queues expected arrivals/errors, a negedge monitor checks them.
module tb_car_motion_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       estop = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = '0;
  logic       req_err;
  logic [3:0] pending;
  logic [2:0] cur_floor;
  logic       moving_up, moving_down, door_open, arrived;

  car_motion_controller #(
    .FLOORS(4), .FLOOR_W(3), .CNT_W(30), .MOVE_TICKS(4), .DOOR_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef ESTOP_EN
    .estop(estop),
`endif
    .req_valid(req_valid),
    .req_floor(req_floor),
    .req_err(req_err),
    .pending(pending),
    .cur_floor(cur_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .arrived(arrived)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int floor; int cyc; int dwell;} arr_t;
  arr_t arr_q[$];
  int   err_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops on arrived / req_err and measures each door dwell.
  int   door_len = 0;
  int   dwell_exp = 0;
  logic in_door = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (arrived) begin
        check("arrival_expected", int'(arr_q.size() > 0), 1);
        if (arr_q.size() > 0) begin
          arr_t a;
          a = arr_q.pop_front();
          check("arrival_floor", int'(cur_floor), a.floor);
          check("arrival_cycle", cyc, a.cyc);
          $display("arrival floor=%0d cycle=%0d", cur_floor, cyc);
          dwell_exp = a.dwell;
        end
        door_len = 0;
        in_door  = 1'b1;
      end
      if (door_open) begin
        door_len++;
      end else if (in_door) begin
        check("door_dwell", door_len, dwell_exp);
        in_door = 1'b0;
      end
      if (req_err) begin
        check("err_expected", int'(err_q.size() > 0), 1);
        if (err_q.size() > 0) check("err_cycle", cyc, err_q.pop_front());
        $display("req_err cycle=%0d", cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = 3'(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((door_open || moving_up || moving_down || pending != 0) && k < 200) begin
      tick();
      k++;
    end
    check("idle_reached", int'(k < 200), 1);
  endtask

  initial begin
    int c;
    repeat (3) tick();
    check("rst_pending", pending, 0);
    check("rst_floor", cur_floor, 0);
    check("rst_up", moving_up, 0);
    check("rst_down", moving_down, 0);
    check("rst_door", door_open, 0);
    check("rst_arrived", arrived, 0);
    check("rst_err", req_err, 0);
    reset = 1'b0;

    // Call for current floor: door 2 cycles after request is driven.
    c = cyc;
    arr_q.push_back('{0, c + 2, 3});
    req(0);
    check("t1_pending_set", pending, 4'b0001);
    tick();
    check("t1_door", door_open, 1);
    check("t1_pending_clr", pending, 0);
    wait_idle();

    // 0 -> 3, then door hold on dwell cycle 2 (5 cycles open total).
    c = cyc;
    arr_q.push_back('{3, c + 14, 5});
    req(3);
    tick();
    check("t2_up", moving_up, 1);
    wait_cycle(c + 5);  check("t2_floor0", cur_floor, 0);
    wait_cycle(c + 6);  check("t2_floor1", cur_floor, 1);
    wait_cycle(c + 10); check("t2_floor2", cur_floor, 2);
    wait_cycle(c + 13); check("t2_up_last", moving_up, 1);
    wait_cycle(c + 14);
    check("t2_floor3", cur_floor, 3);
    check("t2_up_off", moving_up, 0);
    wait_cycle(c + 15);
    req(3);
    check("t2_hold_absorbed", pending, 0);
    check("t2_hold_open", door_open, 1);
    wait_idle();

    // Out-of-range floor.
    c = cyc;
    err_q.push_back(c + 1);
    req(4);
    check("err_pulse", req_err, 1);
    check("err_pending", pending, 0);
    tick();
    check("err_pulse_end", req_err, 0);

    // 3 -> 0 downward.
    c = cyc;
    arr_q.push_back('{0, c + 14, 3});
    req(0);
    tick();
    check("dn_down", moving_down, 1);
    wait_cycle(c + 6);  check("dn_floor2", cur_floor, 2);
    wait_cycle(c + 14); check("dn_floor0", cur_floor, 0);
    wait_idle();

    // Reset mid MOVE_UP with pending {2,3}.
    c = cyc;
    req(2);
    req(3);
    tick();
    check("rs_pending", pending, 4'b1100);
    wait_cycle(c + 7);
    check("rs_floor1", cur_floor, 1);
    check("rs_up", moving_up, 1);
    reset = 1'b1;
    tick();
    check("rs_floor", cur_floor, 0);
    check("rs_pending_clr", pending, 0);
    check("rs_up_off", moving_up, 0);
    check("rs_down_off", moving_down, 0);
    check("rs_door_off", door_open, 0);
    reset = 1'b0;

    // Call 1 issued while passing 0->1: stop at 1 then continue to 3.
    c = cyc;
    arr_q.push_back('{1, c + 6, 3});
    arr_q.push_back('{3, c + 18, 3});
    req(3);
    tick();
    tick();
    req(1);
    check("t3_pending", pending, 4'b1010);
    wait_cycle(c + 7);
    check("t3_door1", door_open, 1);
    check("t3_floor1", cur_floor, 1);
    wait_idle();

    // Floor 2, last_dir UP, pending {0,3}: serve 3 first, then down to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c = cyc;
    arr_q.push_back('{2, c + 10, 3});
    arr_q.push_back('{3, c + 18, 3});
    arr_q.push_back('{0, c + 34, 3});
    req(2);
    wait_cycle(c + 10);
    req(0);
    req(3);
    check("t4_pending", pending, 4'b1001);
    wait_cycle(c + 22); check("t4_down_start", moving_down, 1);
    wait_cycle(c + 33);
    check("t4_down_last", moving_down, 1);
    check("t4_floor1", cur_floor, 1);
    wait_cycle(c + 34);
    check("t4_down_off", moving_down, 0);
    check("t4_door0", door_open, 1);
    wait_idle();
    repeat (2) tick();

    check("arr_queue_drained", arr_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
